tp_filt_seq: RTL and testbench

TP_FILT_SEQ -- requirements
Module: tp_filt_seq

---
 rtl/tp_filt_pkg.sv | 65 ++++++
 rtl/tp_filt_mac.sv | 44 ++++
 rtl/tp_filt_seq.sv | 214 +++++++++++++++++++++
 tb/tb_tp_filt_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tp_filt_pkg.sv
// Shared types, widths and default coefficients for the time-shared first-order IIR filter.
package tp_filt_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 18;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 36;
    localparam int FRAC_W = 15;
    localparam int Q_W    = ACC_W - FRAC_W;

    typedef enum logic [2:0] {
        IDLE, LOAD, MUL_B1, MUL_B2, MUL_A2, STORE, DONE
    } state_e;

    typedef enum logic [1:0] {
        FSEL_BYPASS = 2'd0,
        FSEL_LIGHT  = 2'd1,
        FSEL_MEDIUM = 2'd2,
        FSEL_HEAVY  = 2'd3
    } fsel_e;

    // Each set satisfies B1 + B2 - A2 = 32768 (unity DC gain), with B1 = B2.
    localparam logic signed [COEF_W-1:0] A2_LIGHT  = -18'sd29688;
    localparam logic signed [COEF_W-1:0] B_LIGHT   =  18'sd1540;
    localparam logic signed [COEF_W-1:0] A2_MEDIUM = -18'sd31728;
    localparam logic signed [COEF_W-1:0] B_MEDIUM  =  18'sd520;
    localparam logic signed [COEF_W-1:0] A2_HEAVY  = -18'sd32498;
    localparam logic signed [COEF_W-1:0] B_HEAVY   =  18'sd135;

    localparam logic signed [Q_W-1:0]    Q_MAX    = Q_W'(32767);
    localparam logic signed [Q_W-1:0]    Q_MIN    = Q_W'(-32768);
    localparam logic signed [DATA_W-1:0] DATA_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] DATA_MIN = 16'sh8000;

    function automatic logic signed [COEF_W-1:0] default_a2(input logic [1:0] sel);
        case (sel)
            FSEL_LIGHT:  return A2_LIGHT;
            FSEL_MEDIUM: return A2_MEDIUM;
            FSEL_HEAVY:  return A2_HEAVY;
            default:     return '0;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] default_b(input logic [1:0] sel);
        case (sel)
            FSEL_LIGHT:  return B_LIGHT;
            FSEL_MEDIUM: return B_MEDIUM;
            FSEL_HEAVY:  return B_HEAVY;
            default:     return '0;
        endcase
    endfunction

    // Floor shift by FRAC_W, then clamp into the 16-bit signed range.
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [Q_W-1:0] q;
        q = acc[ACC_W-1:FRAC_W];
        if (q > Q_MAX) begin
            return DATA_MAX;
        end else if (q < Q_MIN) begin
            return DATA_MIN;
        end
        return q[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/tp_filt_mac.sv
// Registered 16x18 signed multiply-accumulate: clear loads the product, otherwise add or subtract it.
module tp_filt_mac
    import tp_filt_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic                     sub_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = PROD_W'(a_i) * PROD_W'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            if (clr_i) begin
                acc_d = ACC_W'(prod);
            end else if (sub_i) begin
                acc_d = acc_q - ACC_W'(prod);
            end else begin
                acc_d = acc_q + ACC_W'(prod);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tp_filt_seq.sv
// Multi-channel first-order IIR sequencer sharing one MAC; one pass per sample tick.
// Define TP_FILT_COEF_WR_EN to add a run-time writable coefficient table.
module tp_filt_seq
    import tp_filt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV    = 220
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W*NUM_CH-1:0]   in_ch,
    input  logic [2*NUM_CH-1:0]        fsel,
`ifdef TP_FILT_COEF_WR_EN
    input  logic                       coef_we,
    input  logic [1:0]                 coef_sel,
    input  logic                       coef_field,
    input  logic signed [COEF_W-1:0]   coef_data,
`endif
    output logic [DATA_W*NUM_CH-1:0]   out_ch,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    if (5 * NUM_CH + 2 >= DIV) begin : g_cfg_check
        $error("tp_filt_seq: DIV must exceed 5*NUM_CH+2");
    end

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CH_W-1:0]           ch_q;
    logic signed [DATA_W-1:0]  samp_q [NUM_CH];
    logic [1:0]                fsel_q [NUM_CH];
    logic signed [DATA_W-1:0]  x1_q   [NUM_CH];
    logic signed [DATA_W-1:0]  y1_q   [NUM_CH];
    logic signed [DATA_W-1:0]  res_q  [NUM_CH];
    logic [DATA_W*NUM_CH-1:0]  out_q;
    logic                      out_valid_q;
    logic                      overrun_q;

    logic                      tick, start, store_en, done;
    logic                      mac_en, mac_clr, mac_sub;
    logic signed [DATA_W-1:0]  mac_a;
    logic signed [COEF_W-1:0]  mac_b;
    logic signed [ACC_W-1:0]   mac_acc;
    logic signed [DATA_W-1:0]  x_cur, x1_cur, y1_cur, y_cur;
    logic [1:0]                fsel_cur;
    logic signed [COEF_W-1:0]  a2_cur, b_cur;

    assign tick     = (cnt_q == CNT_MAX);
    assign x_cur    = samp_q[ch_q];
    assign x1_cur   = x1_q[ch_q];
    assign y1_cur   = y1_q[ch_q];
    assign fsel_cur = fsel_q[ch_q];
    assign y_cur    = (fsel_cur == FSEL_BYPASS) ? x_cur : sat_shift(mac_acc);

`ifdef TP_FILT_COEF_WR_EN
    logic signed [COEF_W-1:0] a2_tab_q [4];
    logic signed [COEF_W-1:0] b_tab_q  [4];
    logic signed [COEF_W-1:0] a2_snap_q[4];
    logic signed [COEF_W-1:0] b_snap_q [4];

    // Writes land in the live table; a pass only ever sees the copy taken at its tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                a2_tab_q[s]  <= default_a2(2'(s));
                b_tab_q[s]   <= default_b(2'(s));
                a2_snap_q[s] <= default_a2(2'(s));
                b_snap_q[s]  <= default_b(2'(s));
            end
        end else begin
            if (coef_we && coef_sel != FSEL_BYPASS) begin
                if (coef_field) begin
                    b_tab_q[coef_sel] <= coef_data;
                end else begin
                    a2_tab_q[coef_sel] <= coef_data;
                end
            end
            if (start) begin
                a2_snap_q <= a2_tab_q;
                b_snap_q  <= b_tab_q;
            end
        end
    end

    assign a2_cur = a2_snap_q[fsel_cur];
    assign b_cur  = b_snap_q[fsel_cur];
`else
    assign a2_cur = default_a2(fsel_cur);
    assign b_cur  = default_b(fsel_cur);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = LOAD;
            LOAD:    state_d = MUL_B1;
            MUL_B1:  state_d = MUL_B2;
            MUL_B2:  state_d = MUL_A2;
            MUL_A2:  state_d = STORE;
            STORE:   state_d = (ch_q == LAST_CH) ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        start    = tick && (state_q == IDLE);
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        mac_sub  = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        store_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            MUL_B1: begin
                mac_en  = 1'b1;
                mac_clr = 1'b1;
                mac_a   = x_cur;
                mac_b   = b_cur;
            end
            MUL_B2: begin
                mac_en = 1'b1;
                mac_a  = x1_cur;
                mac_b  = b_cur;
            end
            MUL_A2: begin
                mac_en  = 1'b1;
                mac_sub = 1'b1;
                mac_a   = y1_cur;
                mac_b   = a2_cur;
            end
            STORE:   store_en = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    tp_filt_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .en_i  (mac_en),
        .clr_i (mac_clr),
        .sub_i (mac_sub),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (mac_acc)
    );

    // Results collect in res_q and are published together so out_ch never shows a partial pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                samp_q[n] <= '0;
                fsel_q[n] <= '0;
                x1_q[n]   <= '0;
                y1_q[n]   <= '0;
                res_q[n]  <= '0;
            end
        end else begin
            if (start) begin
                ch_q <= '0;
                for (int n = 0; n < NUM_CH; n++) begin
                    samp_q[n] <= in_ch[DATA_W*n +: DATA_W];
                    fsel_q[n] <= fsel[2*n +: 2];
                end
            end
            if (store_en) begin
                x1_q[ch_q]  <= x_cur;
                y1_q[ch_q]  <= y_cur;
                res_q[ch_q] <= y_cur;
                if (ch_q != LAST_CH) begin
                    ch_q <= ch_q + CH_W'(1);
                end
            end
            if (done) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    out_q[DATA_W*n +: DATA_W] <= res_q[n];
                end
            end
            out_valid_q <= done;
            if (tick && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out_ch    = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tp_filt_seq.sv
// Directed bench for tp_filt_seq: step response, bypass, pass timing, mid-pass reset and fsel,
// plus the coefficient write path when TP_FILT_COEF_WR_EN is defined.
module tb_tp_filt_seq;

    localparam int NUM_CH   = 4;
    localparam int DIV      = 220;
    localparam int PASS_LAT = 5 * NUM_CH + 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [16*NUM_CH-1:0]   in_ch;
    logic [2*NUM_CH-1:0]    fsel;
    logic [16*NUM_CH-1:0]   out_ch;
    logic                   out_valid;
    logic                   busy;
    logic                   overrun;
`ifdef TP_FILT_COEF_WR_EN
    logic                   coef_we;
    logic [1:0]             coef_sel;
    logic                   coef_field;
    logic signed [17:0]     coef_data;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tp_filt_seq #(.NUM_CH(NUM_CH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_ch      (in_ch),
        .fsel       (fsel),
`ifdef TP_FILT_COEF_WR_EN
        .coef_we    (coef_we),
        .coef_sel   (coef_sel),
        .coef_field (coef_field),
        .coef_data  (coef_data),
`endif
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input int sample, input int fs);
        in_ch[16*ch +: 16] = 16'(sample);
        fsel[2*ch +: 2]    = 2'(fs);
    endtask

    function automatic int chOut(input int ch);
        logic signed [15:0] v;
        v = out_ch[16*ch +: 16];
        return int'(v);
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string tag, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            stepCycle();
            if (out_valid) begin
                at = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s: out_valid not seen within %0d cycles", tag, limit);
    endtask

    task automatic waitBusy(input string tag, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            stepCycle();
            if (busy) begin
                at = cyc;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s: busy not seen within %0d cycles", tag, limit);
    endtask

    task automatic checkPass(input string tag, input int e0, input int e1, input int e2, input int e3);
        checkOutput({tag, "_ch0"}, chOut(0), e0);
        checkOutput({tag, "_ch1"}, chOut(1), e1);
        checkOutput({tag, "_ch2"}, chOut(2), e2);
        checkOutput({tag, "_ch3"}, chOut(3), e3);
    endtask

    initial begin
        int relRef, tValid1, tValid2, tBusy;

        reset = 1'b1;
        in_ch = '0;
        fsel  = '0;
`ifdef TP_FILT_COEF_WR_EN
        coef_we    = 1'b0;
        coef_sel   = 2'd0;
        coef_field = 1'b0;
        coef_data  = '0;
`endif
        applyStimulus(0, 16384, 3);
        applyStimulus(1, -1234, 0);
        applyStimulus(2, 8000, 3);
        applyStimulus(3, -20000, 1);

        repeat (3) stepCycle();
        checkOutput("rst_out_ch0", chOut(0), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_overrun", int'(overrun), 0);

        // Latencies are measured from the last cycle in which reset was sampled high.
        relRef = cyc - 1;
        reset  = 1'b0;
        waitValid("first_valid", 400, tValid1);
        checkOutput("first_valid_lat", tValid1 - relRef, DIV + PASS_LAT);
        // Heavy: 135*16384>>>15 = 67; bypass passes -1234; heavy 8000 -> 32; light -20000 -> -940.
        checkPass("pass1", 67, -1234, 32, -940);
        stepCycle();
        checkOutput("valid_pulse_width", int'(out_valid), 0);
        repeat (50) stepCycle();
        checkOutput("hold_ch0", chOut(0), 67);

        waitBusy("pass2_busy", 300, tBusy);
        repeat (3) stepCycle();
        applyStimulus(2, 8000, 0);
        waitValid("pass2_valid", 300, tValid2);
        checkOutput("tick_to_valid", tValid2 - tBusy + 1, PASS_LAT);
        checkOutput("valid_period", tValid2 - tValid1, DIV);
        // ch2 still heavy this pass: (2*135*8000 + 32498*32)>>>15 = 97.
        checkPass("pass2", 201, -1234, 97, -2732);

        waitValid("pass3_valid", 300, tValid1);
        checkOutput("valid_period2", tValid1 - tValid2, DIV);
        checkPass("pass3", 334, -1234, 8000, -4356);
        checkOutput("no_overrun", int'(overrun), 0);

        waitBusy("rst_busy", 300, tBusy);
        repeat (9) stepCycle();
        reset = 1'b1;
        stepCycle();
        relRef = cyc - 1;
        reset  = 1'b0;
        checkOutput("midrst_out_ch0", chOut(0), 0);
        checkOutput("midrst_out_ch3", chOut(3), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        waitValid("midrst_valid", 400, tValid1);
        checkOutput("midrst_valid_lat", tValid1 - relRef, DIV + PASS_LAT);
        checkPass("midrst_pass", 67, -1234, 8000, -940);

`ifdef TP_FILT_COEF_WR_EN
        waitBusy("coef_busy", 300, tBusy);
        coef_we    = 1'b1;
        coef_sel   = 2'd3;
        coef_field = 1'b1;
        coef_data  = 18'sd0;
        stepCycle();
        coef_we = 1'b0;
        waitValid("coef_pass_a", 300, tValid1);
        checkOutput("coef_cur_pass_ch0", chOut(0), 201);
        waitValid("coef_pass_b", 300, tValid2);
        // B = 0 leaves only the feedback term: 32498*201>>>15 = 199.
        checkOutput("coef_next_pass_ch0", chOut(0), 199);
        checkOutput("coef_next_pass_ch2", chOut(2), 8000);
`endif

        checkOutput("final_overrun", int'(overrun), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
